// File: rtl/alu_share_arbiter_if.sv
// Bundle between alu_share_arbiter and its environment: the two requester ports,
// the shared response channel and the ALU operand/result wires.
interface alu_share_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0;
  logic [31:0] req_a1;
  logic [31:0] req_b0;
  logic [31:0] req_b1;
  logic [3:0]  req_ctrl0;
  logic [3:0]  req_ctrl1;
  logic [4:0]  req_shamt0;
  logic [4:0]  req_shamt1;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_ctrl;
  logic [5:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_illegal;

  // master is the surroundings: both requesters plus the ALU itself
  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_ctrl0, req_ctrl1,
           req_shamt0, req_shamt1, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_in1, alu_in2, alu_ctrl, alu_shamt,
           rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_ctrl0, req_ctrl1,
           req_shamt0, req_shamt1, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_in1, alu_in2, alu_ctrl, alu_shamt,
           rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one single-cycle ALU between two requesters;
// one operation in flight, response held until the owner acknowledges it.
module alu_share_arbiter (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_port_q, last_port_d;
  logic        owner_q, owner_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        illegal_q, illegal_d;
  logic [1:0]  grant;

  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13: is_legal = 1'b1;
      default:                                    is_legal = 1'b0;
    endcase
  endfunction

  // A lone requester always wins; on a tie the port not served last wins.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE) begin
      grant[0] = bus.req_valid[0] & (~bus.req_valid[1] | last_port_q);
      grant[1] = bus.req_valid[1] & (~bus.req_valid[0] | ~last_port_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    last_port_d = last_port_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    shamt_d     = shamt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    case (state_q)
      IDLE: begin
        if (|(bus.req_valid & grant)) begin
          owner_d     = grant[1];
          last_port_d = grant[1];
          a_d         = grant[1] ? bus.req_a1     : bus.req_a0;
          b_d         = grant[1] ? bus.req_b1     : bus.req_b0;
          ctrl_d      = grant[1] ? bus.req_ctrl1  : bus.req_ctrl0;
          shamt_d     = grant[1] ? bus.req_shamt1 : bus.req_shamt0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        result_d  = bus.alu_result;
        zero_d    = bus.alu_zero;
        illegal_d = ~is_legal(ctrl_q);
        state_d   = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_port_q <= 1'b1;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      shamt_q     <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_port_q <= last_port_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      shamt_q     <= shamt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.req_ready   = grant;
  assign bus.alu_in1     = a_q;
  assign bus.alu_in2     = b_q;
  assign bus.alu_ctrl    = ctrl_q;
  assign bus.alu_shamt   = {1'b0, shamt_q};
  assign bus.rsp_valid   = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.rsp_illegal = illegal_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural MIPS ALU on the far side;
// inputs are driven and outputs sampled on the falling edge.
module tb_alu_share_arbiter;

  logic clk;
  logic rst_n;
  int   checks_cnt;
  int   errors_cnt;

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.alu_result = 32'd0;
    case (bus.alu_ctrl)
      4'd0:  bus.alu_result = bus.alu_in1 & bus.alu_in2;
      4'd1:  bus.alu_result = bus.alu_in1 | bus.alu_in2;
      4'd2:  bus.alu_result = bus.alu_in1 + bus.alu_in2;
      4'd6:  bus.alu_result = bus.alu_in1 - bus.alu_in2;
      4'd7:  bus.alu_result = ($signed(bus.alu_in1) < $signed(bus.alu_in2)) ? 32'd1 : 32'd0;
      4'd12: bus.alu_result = ~(bus.alu_in1 | bus.alu_in2);
      4'd13: bus.alu_result = bus.alu_in1 << bus.alu_shamt;
      default: bus.alu_result = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s got 0x%08h expected 0x%08h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] ctrl, input logic [4:0] sh);
    if (p == 0) begin
      bus.req_a0 = a; bus.req_b0 = b; bus.req_ctrl0 = ctrl; bus.req_shamt0 = sh;
    end else begin
      bus.req_a1 = a; bus.req_b1 = b; bus.req_ctrl1 = ctrl; bus.req_shamt1 = sh;
    end
  endtask

  // One full transaction from IDLE; returns to IDLE at the end.
  task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] ctrl, input logic [4:0] sh,
                        input logic [31:0] exp_res, input logic exp_zero, input logic exp_ill);
    logic [1:0] pbit;
    pbit = (p == 0) ? 2'b01 : 2'b10;
    bus.rsp_ready = 2'b00;
    set_port(p, a, b, ctrl, sh);
    bus.req_valid = pbit;
    #1;
    check("op_req_ready", {30'd0, bus.req_ready}, {30'd0, pbit});
    @(negedge clk);
    bus.req_valid = 2'b00;
    check("exec_alu_in1", bus.alu_in1, a);
    check("exec_alu_in2", bus.alu_in2, b);
    check("exec_alu_ctrl", {28'd0, bus.alu_ctrl}, {28'd0, ctrl});
    check("exec_alu_shamt", {26'd0, bus.alu_shamt}, {27'd0, sh});
    check("exec_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    check("resp_valid", {30'd0, bus.rsp_valid}, {30'd0, pbit});
    check("resp_result", bus.rsp_result, exp_res);
    check("resp_zero", {31'd0, bus.rsp_zero}, {31'd0, exp_zero});
    check("resp_illegal", {31'd0, bus.rsp_illegal}, {31'd0, exp_ill});
    $display("txn port=%0d a=0x%08h b=0x%08h ctrl=%0d shamt=%0d -> result=0x%08h zero=%0b illegal=%0b",
             p, a, b, ctrl, sh, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal);
    bus.rsp_ready = pbit;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    check("after_ack_valid", {30'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int last_acc;
    logic [1:0] exp_g;
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    set_port(0, 32'd9, 32'd9, 4'd6, 5'd0);
    set_port(1, 32'd3, 32'd4, 4'd7, 5'd0);
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    check("rst_alu_in1", bus.alu_in1, 32'd0);
    check("rst_alu_in2", bus.alu_in2, 32'd0);
    check("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    check("rst_alu_shamt", {26'd0, bus.alu_shamt}, 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_rsp_zero", {31'd0, bus.rsp_zero}, 32'd0);
    check("rst_rsp_illegal", {31'd0, bus.rsp_illegal}, 32'd0);
    bus.req_valid = 2'b11;
    #1;
    check("rst_tie_grant", {30'd0, bus.req_ready}, 32'd1);
    rst_n = 1'b1;

    // Tie: both valid continuously, acks always high -> grants 0,1,0,1
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      check("rr_grant", {30'd0, bus.req_ready}, {30'd0, exp_g});
      @(negedge clk);
      @(negedge clk);
      check("rr_rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, exp_g});
      check("rr_result", bus.rsp_result, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("rr_zero", {31'd0, bus.rsp_zero}, (i % 2 == 1) ? 32'd0 : 32'd1);
      $display("txn rr op=%0d port=%0d result=0x%08h zero=%0b", i, i % 2, bus.rsp_result, bus.rsp_zero);
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;

    // Port 0 ADD
    run_op(0, 32'd5, 32'd7, 4'd2, 5'd0, 32'd12, 1'b0, 1'b0);

    // Backpressure on port 1 OR; non-owner ack and port 0 request must be ignored
    set_port(1, 32'h000000F0, 32'h0000000F, 4'd1, 5'd0);
    bus.req_valid = 2'b10;
    #1;
    check("bp_req_ready", {30'd0, bus.req_ready}, 32'd2);
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    #1;
    check("bp_exec_ready", {30'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("bp_rsp_valid", {30'd0, bus.rsp_valid}, 32'd2);
      check("bp_result", bus.rsp_result, 32'h000000FF);
      check("bp_req_ready_held", {30'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
    end
    $display("txn port=1 OR held 10 cycles result=0x%08h", bus.rsp_result);
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    #1;
    check("bp_idle_ready", {30'd0, bus.req_ready}, 32'd1);
    check("bp_idle_valid", {30'd0, bus.rsp_valid}, 32'd0);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    @(negedge clk);

    // SLL and illegal code
    run_op(0, 32'd1, 32'd0, 4'd13, 5'd31, 32'h80000000, 1'b0, 1'b0);
    run_op(0, 32'h00001234, 32'h00000055, 4'd5, 5'd0, 32'd0, 1'b1, 1'b1);

    // Reset in the middle of EXEC
    set_port(0, 32'h000000AA, 32'd1, 4'd2, 5'd0);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b00;
    check("mid_exec_in1", bus.alu_in1, 32'h000000AA);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {30'd0, bus.rsp_valid}, 32'd0);
    check("async_rst_in1", bus.alu_in1, 32'd0);
    check("async_rst_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    @(negedge clk);
    check("rst_hold_valid", {30'd0, bus.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    check("post_rst_tie", {30'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("no_stale_rsp", {30'd0, bus.rsp_valid}, 32'd0);
    $display("txn reset during EXEC discarded");

    // Port 1 streaming with ack held high
    set_port(1, 32'd10, 32'd3, 4'd6, 5'd0);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b10;
    accepts = 0;
    last_acc = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      #1;
      if (bus.req_ready[0])
        check("stream_port0_grant", {31'd0, bus.req_ready[0]}, 32'd0);
      if (bus.req_ready[1] && bus.req_valid[1]) begin
        accepts++;
        if (accepts > 1) check("stream_spacing", cyc - last_acc, 32'd3);
        last_acc = cyc;
        $display("txn stream accept cycle=%0d", cyc);
      end
      if (bus.rsp_valid[1]) check("stream_result", bus.rsp_result, 32'd7);
      @(negedge clk);
    end
    check("stream_accepts", accepts, 32'd5);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
